// File: rtl/framing_pkg.sv
// ---------------------------------------------------------------------------
// framing_pkg: shared states, PN9 whitening constants and line-code chips.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package framing_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_SYNC     = 3'd2,
      ST_PAYLOAD  = 3'd3,
      ST_FSC      = 3'd4,
      ST_STALL    = 3'd5
   } state_e;

   localparam int          PN9_TAP_A         = 0;
   localparam int          PN9_TAP_B         = 5;
   localparam logic [8:0]  PN9_DEFAULT_SEED  = 9'h1FF;

   localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hD391;
   localparam logic [7:0]  DEFAULT_FSC_CODE  = 8'h7E;
   localparam logic [7:0]  PREAMBLE_BYTE     = 8'h55;

   // Chip pairs, first chip in bit [1].
   localparam logic [1:0]  MANCH_ONE         = 2'b10;
   localparam logic [1:0]  MANCH_ZERO        = 2'b01;

   function automatic logic [1:0] manchester_chips(input logic b);
      return b ? MANCH_ONE : MANCH_ZERO;
   endfunction

endpackage

`default_nettype wire

// File: rtl/framing_pn9_whitener.sv
// ---------------------------------------------------------------------------
// framing_pn9_whitener: PN9 LFSR with load/advance/freeze and XOR output.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module framing_pn9_whitener
   import framing_pkg::*;
#(
   parameter logic [8:0] SEED = PN9_DEFAULT_SEED
)(
   input  logic clk,
   input  logic reset_n,
   input  logic load_i,
   input  logic advance_i,
   input  logic freeze_i,
   input  logic data_bit_i,
   output logic whitened_o
);

   logic [8:0] lfsr_q;
   logic [8:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = SEED;
      end else if (advance_i && !freeze_i) begin
         lfsr_d = {lfsr_q[PN9_TAP_A] ^ lfsr_q[PN9_TAP_B], lfsr_q[8:1]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign whitened_o = data_bit_i ^ lfsr_q[0];

endmodule

`default_nettype wire

// File: rtl/framing_encoding.sv
// ---------------------------------------------------------------------------
// framing_encoding: TX framer, preamble/sync/PN9 payload/FSC, one chip per clk.
// Manchester line code when FRAMING_ENC_MANCHESTER_EN is defined, else NRZ. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module framing_encoding
   import framing_pkg::*;
#(
   parameter int          PREAMBLE_BYTES = 4,
   parameter logic [15:0] SYNC_WORD      = DEFAULT_SYNC_WORD,
   parameter logic [7:0]  FSC_CODE       = DEFAULT_FSC_CODE,
   parameter logic [8:0]  PN9_SEED       = PN9_DEFAULT_SEED
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   input  logic       data_in_last,
   output logic       data_in_ready,
   output logic       data_out,
   output logic       data_out_valid,
   output logic       frame_active,
   output logic       fsc_end,
   output logic       underrun
);

   state_e     state_q, state_d;
   logic [2:0] bit_q, bit_d;
   logic [3:0] byte_q, byte_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   logic       hold_last_q, hold_last_d;
   logic [7:0] shift_q, shift_d;
   logic       shift_last_q, shift_last_d;
   logic       last_seen_q, last_seen_d;
   logic       underrun_q, underrun_d;

   logic       w_accept;
   logic       w_tx;
   logic       w_chip_last;
   logic       w_bit_end;
   logic       w_byte_end;
   logic       w_lfsr_load;
   logic [7:0] w_cur_byte;
   logic       w_raw_bit;
   logic       w_white_bit;
   logic       w_line_bit;

   assign data_in_ready = !hold_full_q && !last_seen_q && (state_q != ST_FSC);
   assign w_accept      = data_in_valid && data_in_ready;
   assign w_tx          = (state_q == ST_PREAMBLE) || (state_q == ST_SYNC) ||
                          (state_q == ST_PAYLOAD)  || (state_q == ST_FSC);
   assign w_bit_end     = w_tx && w_chip_last;
   assign w_byte_end    = w_bit_end && (bit_q == 3'd7);

   always_comb begin
      case (state_q)
         ST_PREAMBLE: w_cur_byte = PREAMBLE_BYTE;
         ST_SYNC:     w_cur_byte = byte_q[0] ? SYNC_WORD[7:0] : SYNC_WORD[15:8];
         ST_PAYLOAD:  w_cur_byte = shift_q;
         ST_FSC:      w_cur_byte = FSC_CODE;
         default:     w_cur_byte = 8'h00;
      endcase
   end

   assign w_raw_bit  = w_cur_byte[3'd7 - bit_q];
   assign w_line_bit = (state_q == ST_PAYLOAD) ? w_white_bit : w_raw_bit;

   framing_pn9_whitener #(
      .SEED       (PN9_SEED)
   ) u_whitener (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (w_lfsr_load),
      .advance_i  ((state_q == ST_PAYLOAD) && w_bit_end),
      .freeze_i   (state_q == ST_STALL),
      .data_bit_i (w_raw_bit),
      .whitened_o (w_white_bit)
   );

`ifdef FRAMING_ENC_MANCHESTER_EN
   logic       chip_q;
   logic [1:0] w_chips;

   assign w_chips     = manchester_chips(w_line_bit);
   assign w_chip_last = chip_q;
   assign data_out    = w_tx && (chip_q ? w_chips[0] : w_chips[1]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chip_q <= 1'b0;
      end else if (w_tx) begin
         chip_q <= ~chip_q;
      end
   end
`else
   assign w_chip_last = 1'b1;
   assign data_out    = w_tx && w_line_bit;
`endif

   always_comb begin
      state_d      = state_q;
      bit_d        = bit_q;
      byte_d       = byte_q;
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      hold_last_d  = hold_last_q;
      shift_d      = shift_q;
      shift_last_d = shift_last_q;
      last_seen_d  = last_seen_q;
      underrun_d   = 1'b0;
      w_lfsr_load  = 1'b0;

      if (w_bit_end) begin
         bit_d = bit_q + 3'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               hold_d      = data_in;
               hold_full_d = 1'b1;
               hold_last_d = data_in_last;
               last_seen_d = data_in_last;
               byte_d      = 4'd0;
               state_d     = ST_PREAMBLE;
            end
         end
         ST_PREAMBLE: begin
            if (w_byte_end) begin
               if (byte_q == 4'(PREAMBLE_BYTES - 1)) begin
                  byte_d  = 4'd0;
                  state_d = ST_SYNC;
               end else begin
                  byte_d  = byte_q + 4'd1;
               end
            end
         end
         ST_SYNC: begin
            if (w_byte_end) begin
               if (byte_q == 4'd1) begin
                  shift_d      = hold_q;
                  shift_last_d = hold_last_q;
                  hold_full_d  = 1'b0;
                  w_lfsr_load  = 1'b1;
                  byte_d       = 4'd0;
                  state_d      = ST_PAYLOAD;
               end else begin
                  byte_d       = byte_q + 4'd1;
               end
            end
         end
         ST_PAYLOAD: begin
            if (w_byte_end) begin
               if (shift_last_q) begin
                  state_d      = ST_FSC;
               end else if (hold_full_q) begin
                  shift_d      = hold_q;
                  shift_last_d = hold_last_q;
                  hold_full_d  = 1'b0;
               end else if (w_accept) begin
                  // Byte arriving on the boundary cycle goes straight to the shifter.
                  shift_d      = data_in;
                  shift_last_d = data_in_last;
                  last_seen_d  = data_in_last;
               end else begin
                  underrun_d   = 1'b1;
                  state_d      = ST_STALL;
               end
            end else if (w_accept) begin
               hold_d      = data_in;
               hold_full_d = 1'b1;
               hold_last_d = data_in_last;
               last_seen_d = data_in_last;
            end
         end
         ST_STALL: begin
            if (w_accept) begin
               shift_d      = data_in;
               shift_last_d = data_in_last;
               last_seen_d  = data_in_last;
               state_d      = ST_PAYLOAD;
            end
         end
         ST_FSC: begin
            if (w_byte_end) begin
               last_seen_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         bit_q        <= 3'd0;
         byte_q       <= 4'd0;
         hold_q       <= 8'h00;
         hold_full_q  <= 1'b0;
         hold_last_q  <= 1'b0;
         shift_q      <= 8'h00;
         shift_last_q <= 1'b0;
         last_seen_q  <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_q        <= bit_d;
         byte_q       <= byte_d;
         hold_q       <= hold_d;
         hold_full_q  <= hold_full_d;
         hold_last_q  <= hold_last_d;
         shift_q      <= shift_d;
         shift_last_q <= shift_last_d;
         last_seen_q  <= last_seen_d;
         underrun_q   <= underrun_d;
      end
   end

   assign data_out_valid = w_tx;
   assign frame_active   = (state_q != ST_IDLE);
   assign fsc_end        = (state_q == ST_FSC) && w_byte_end;
   assign underrun       = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_framing_encoding.sv
// ---------------------------------------------------------------------------
// tb_framing_encoding: randomized frames checked against a bit-level frame model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_framing_encoding;

   localparam int          PRE  = 4;
   localparam logic [15:0] SYNC = 16'hD391;
   localparam logic [7:0]  FSC  = 8'h7E;
`ifdef FRAMING_ENC_MANCHESTER_EN
   localparam int          CPB  = 2;
`else
   localparam int          CPB  = 1;
`endif

   logic       clk           = 1'b0;
   logic       reset_n       = 1'b0;
   logic [7:0] data_in       = 8'h00;
   logic       data_in_valid = 1'b0;
   logic       data_in_last  = 1'b0;
   logic       data_in_ready;
   logic       data_out;
   logic       data_out_valid;
   logic       frame_active;
   logic       fsc_end;
   logic       underrun;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] pl_q[$];
   bit         exp_q[$];
   bit         cap_q[$];
   bit         pn[0:1023];

   always #5 clk = ~clk;

   framing_encoding dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_in_last   (data_in_last),
      .data_in_ready  (data_in_ready),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .frame_active   (frame_active),
      .fsc_end        (fsc_end),
      .underrun       (underrun)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic bit cap_bit(input int i);
      return (i < cap_q.size()) ? cap_q[i] : 1'b0;
   endfunction

   task automatic check_idle_outputs(input string pfx);
      chk({pfx, "_data_out"},       data_out,       0);
      chk({pfx, "_data_out_valid"}, data_out_valid, 0);
      chk({pfx, "_frame_active"},   frame_active,   0);
      chk({pfx, "_fsc_end"},        fsc_end,        0);
      chk({pfx, "_underrun"},       underrun,       0);
      chk({pfx, "_ready"},          data_in_ready,  1);
   endtask

   // Line bits of a whole frame for the payload in pl_q, expanded to chips.
   task automatic build_expected();
      logic [7:0]  v;
      logic [15:0] sw;
      int          n;
      sw = SYNC;
      n  = pl_q.size();
      exp_q.delete();
      for (int b = 0; b < PRE + 3 + n; b++) begin
         if (b < PRE)               v = 8'h55;
         else if (b == PRE)         v = sw[15:8];
         else if (b == PRE + 1)     v = sw[7:0];
         else if (b < PRE + 2 + n)  v = pl_q[b - PRE - 2];
         else                       v = FSC;
         for (int j = 7; j >= 0; j--) begin
            bit t;
            t = v[j];
            if (b >= PRE + 2 && b < PRE + 2 + n) t = t ^ pn[(b - PRE - 2) * 8 + (7 - j)];
            exp_q.push_back(t);
            if (CPB == 2) exp_q.push_back(~t);
         end
      end
   endtask

   task automatic run_frame(input int gap_idx, input int gap_cycles, input int exp_ur,
                            input int abort_cyc);
      int         idx, cyc, first_acc, first_valid, fsc_pos, ur, hold_off, stall_acc, gaps, n, off;
      bit         done, aborted;
      logic [7:0] a, e;
      idx = 0; cyc = 0; first_acc = -1; first_valid = -1; fsc_pos = -1; ur = 0;
      hold_off = 0; stall_acc = -1; gaps = 0; done = 0; aborted = 0;
      n = pl_q.size();
      cap_q.delete();
      build_expected();
      while (!done && cyc < 4000) begin
         @(negedge clk);
         if (stall_acc >= 0 && cyc == stall_acc + 1) chk("resume_valid", data_out_valid, 1);
         if (data_out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            cap_q.push_back(data_out);
         end else if (frame_active && first_valid >= 0) begin
            gaps++;
         end
         if (underrun) ur++;
         if (fsc_end) begin
            fsc_pos = cap_q.size();
            done    = 1;
         end
         data_in_valid = 1'b0;
         data_in_last  = 1'b0;
         if (abort_cyc >= 0 && cyc == abort_cyc) begin
            chk("active_before_reset", frame_active, 1);
            reset_n = 1'b0;
            #1;
            check_idle_outputs("midreset");
            aborted = 1;
            done    = 1;
         end else if (!done && idx < n) begin
            if (idx == gap_idx && hold_off < gap_cycles) begin
               hold_off++;
            end else begin
               data_in_valid = 1'b1;
               data_in       = pl_q[idx];
               data_in_last  = (idx == n - 1);
               if (data_in_ready) begin
                  if (idx == 0) first_acc = cyc;
                  if (frame_active && !data_out_valid) stall_acc = cyc;
                  idx++;
               end
            end
         end
         cyc++;
      end
      data_in_valid = 1'b0;
      data_in_last  = 1'b0;
      if (aborted) begin
         @(negedge clk);
         reset_n = 1'b1;
         return;
      end
      chk("done_in_budget", done, 1);
      chk("first_accept_cycle", first_acc, 0);
      chk("first_chip_latency", first_valid - first_acc, 1);
      chk("frame_len", cap_q.size(), exp_q.size());
      chk("fsc_end_pos", fsc_pos, exp_q.size());
      chk("underrun_pulses", ur, exp_ur);
      if (exp_ur == 0) chk("line_gaps", gaps, 0);
      for (int g = 0; g < exp_q.size() / 8; g++) begin
         a = 8'h00; e = 8'h00;
         for (int j = 0; j < 8; j++) begin
            a[7 - j] = cap_bit(g * 8 + j);
            e[7 - j] = exp_q[g * 8 + j];
         end
         chk($sformatf("chips[%0d]", g), a, e);
      end
      off = (PRE + 2) * 8;
      for (int k = 0; k < n; k++) begin
         a = 8'h00;
         for (int j = 0; j < 8; j++) a[7 - j] = cap_bit((off + 8 * k + j) * CPB) ^ pn[8 * k + j];
         chk($sformatf("descrambled[%0d]", k), a, pl_q[k]);
      end
      if (pl_q[0] == 8'h00) begin
         a = 8'h00;
         for (int j = 0; j < 8; j++) a[7 - j] = cap_bit((off + j) * CPB);
         chk("seed_byte", a, 8'hFF);
      end
   endtask

   initial begin
      int s, fb, len;
      s = 'h1FF;
      for (int i = 0; i < 1024; i++) begin
         pn[i] = s[0];
         fb    = (s ^ (s >> 5)) & 1;
         s     = (s >> 1) | (fb << 8);
      end

      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset_n = 1'b1;

      pl_q = '{8'h00};
      run_frame(-1, 0, 0, -1);
      repeat (3) @(negedge clk);

      pl_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_frame(-1, 0, 0, -1);
      repeat (2) @(negedge clk);
      run_frame(2, 20 * CPB, 1, -1);
      repeat (2) @(negedge clk);

      pl_q = '{8'h00};
      run_frame(-1, 0, 0, -1);
      run_frame(-1, 0, 0, -1);

      pl_q = '{8'hA5, 8'h3C, 8'hF0};
      run_frame(-1, 0, 0, 1 + (PRE + 2) * 8 * CPB + 3 * CPB);
      pl_q = '{8'h00};
      run_frame(-1, 0, 0, -1);

      for (int r = 0; r < 6; r++) begin
         pl_q.delete();
         len = $urandom_range(1, 6);
         for (int k = 0; k < len; k++) pl_q.push_back(8'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_frame(-1, 0, 0, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
